// File: rtl/uart_boot_loader_if.sv
// Byte-in / word-out bus of the UART boot loader.
// master: the loader (consumes received bytes, issues memory writes).
// slave:  the environment (UART receiver plus program memory).
interface uart_boot_loader_if #(
  parameter int unsigned ADDR_WIDTH = 5
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_ack;

  modport master (
    input  rx_data, rx_valid, mem_ack,
    output mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_data, rx_valid, mem_ack,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/uart_boot_loader.sv
// UART boot loader: packs received bytes little-endian into 32-bit words,
// writes WORD_COUNT words to program memory, then releases the CPU reset.
module uart_boot_loader #(
  parameter int unsigned WORD_COUNT = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  uart_boot_loader_if.master  bus,
  output logic                cpu_rst,
  output logic                boot_done,
  output logic                overrun
);

  typedef enum logic [1:0] {RECV, WRITE, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(WORD_COUNT - 1);

  state_t                state_q, state_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [7:0]            hold_q, hold_d;
  logic                  hold_vld_q, hold_vld_d;
  logic                  overrun_q, overrun_d;
  logic                  take;
  logic [7:0]            take_byte;

  // Next-state and datapath: byte assembly, write handshake, holding byte
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    wdata_d    = wdata_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    overrun_d  = overrun_q;
    take       = 1'b0;
    take_byte  = '0;

    unique case (state_q)
      RECV: begin
        // A held byte is always older than a byte arriving now, so it is
        // consumed first and the new byte takes its place in the holder.
        if (hold_vld_q) begin
          take       = 1'b1;
          take_byte  = hold_q;
          hold_vld_d = bus.rx_valid;
          if (bus.rx_valid) hold_d = bus.rx_data;
        end else if (bus.rx_valid) begin
          take      = 1'b1;
          take_byte = bus.rx_data;
        end
        if (take) begin
          wdata_d[{byte_idx_q, 3'b000} +: 8] = take_byte;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        if (bus.rx_valid) begin
          if (hold_vld_q) begin
            overrun_d = 1'b1;
          end else begin
            hold_d     = bus.rx_data;
            hold_vld_d = 1'b1;
          end
        end
        if (bus.mem_ack) begin
          byte_idx_d = '0;
          if (word_idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            word_idx_d = word_idx_q + 1'b1;
            state_d    = RECV;
          end
        end
      end
      DONE: ;
      default: state_d = RECV;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= RECV;
      byte_idx_q <= '0;
      word_idx_q <= '0;
      wdata_q    <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.mem_we    = (state_q == WRITE);
  assign bus.mem_addr  = word_idx_q;
  assign bus.mem_wdata = wdata_q;
  assign cpu_rst       = (state_q != DONE);
  assign boot_done     = (state_q == DONE);
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: inputs change and outputs are
// checked on the falling edge of sys_clk.
module tb_uart_boot_loader;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic cpu_rst, boot_done, overrun;
  int   checks = 0;
  int   errors = 0;

  uart_boot_loader_if #(.ADDR_WIDTH(5)) bus ();

  uart_boot_loader #(.WORD_COUNT(32), .ADDR_WIDTH(5)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .bus       (bus.master),
    .cpu_rst   (cpu_rst),
    .boot_done (boot_done),
    .overrun   (overrun)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic do_reset();
    sys_rst = 1'b1;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge sys_clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_we(input int budget);
    for (int i = 0; i < budget && bus.mem_we !== 1'b1; i++) @(negedge sys_clk);
    check("wait_we", {31'd0, bus.mem_we}, 32'd1);
  endtask

  task automatic do_ack();
    bus.mem_ack = 1'b1;
    @(negedge sys_clk);
    bus.mem_ack = 1'b0;
    check("ack_we_low", {31'd0, bus.mem_we}, 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.mem_ack  = 1'b0;
    @(negedge sys_clk);
    do_reset();
    check("rst_we",      {31'd0, bus.mem_we}, 32'd0);
    check("rst_addr",    {27'd0, bus.mem_addr}, 32'd0);
    check("rst_wdata",   bus.mem_wdata, 32'd0);
    check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("rst_done",    {31'd0, boot_done}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);

    // First word: write appears the cycle after the fourth byte
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34);
    check("w0_we_early", {31'd0, bus.mem_we}, 32'd0);
    send_byte(8'h12);
    check("w0_we",    {31'd0, bus.mem_we}, 32'd1);
    check("w0_addr",  {27'd0, bus.mem_addr}, 32'd0);
    check("w0_wdata", bus.mem_wdata, 32'h12345678);
    do_ack();
    check("w0_addr_next", {27'd0, bus.mem_addr}, 32'd1);

    // Reset mid-word discards the partial word and restarts at address 0
    send_byte(8'hA1); send_byte(8'hA2);
    do_reset();
    send_word(32'h04030201);
    check("rw_we",    {31'd0, bus.mem_we}, 32'd1);
    check("rw_addr",  {27'd0, bus.mem_addr}, 32'd0);
    check("rw_wdata", bus.mem_wdata, 32'h04030201);
    do_ack();

    // Delayed ack with one byte arriving during WRITE
    send_word(32'h44332211);
    for (int k = 0; k < 5; k++) begin
      bus.rx_data  = 8'hAA;
      bus.rx_valid = (k == 1);
      @(negedge sys_clk);
      bus.rx_valid = 1'b0;
      check("hold_we",    {31'd0, bus.mem_we}, 32'd1);
      check("hold_addr",  {27'd0, bus.mem_addr}, 32'd1);
      check("hold_wdata", bus.mem_wdata, 32'h44332211);
    end
    do_ack();
    send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    wait_we(10);
    check("held_addr",    {27'd0, bus.mem_addr}, 32'd2);
    check("held_wdata",   bus.mem_wdata, 32'hDDCCBBAA);
    check("held_overrun", {31'd0, overrun}, 32'd0);
    do_ack();

    // Two bytes during one WRITE: second is dropped, overrun sticks
    send_word(32'h04030201);
    check("ov_addr", {27'd0, bus.mem_addr}, 32'd3);
    send_byte(8'hEE);
    send_byte(8'hFF);
    check("ov_set", {31'd0, overrun}, 32'd1);
    do_ack();
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h07);
    wait_we(10);
    check("ov_addr_next",  {27'd0, bus.mem_addr}, 32'd4);
    check("ov_wdata_next", bus.mem_wdata, 32'h070605EE);
    check("ov_sticky",     {31'd0, overrun}, 32'd1);
    do_ack();

    // Full load with ack tied high
    do_reset();
    check("rst2_overrun", {31'd0, overrun}, 32'd0);
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 32; i++) begin
      w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      send_word(w);
      check("load_we",    {31'd0, bus.mem_we}, 32'd1);
      check("load_addr",  {27'd0, bus.mem_addr}, 32'(i));
      check("load_wdata", bus.mem_wdata, w);
      check("load_pre_done", {31'd0, boot_done}, 32'd0);
      @(negedge sys_clk);
      check("load_we_pulse", {31'd0, bus.mem_we}, 32'd0);
      check("load_cpu_rst",  {31'd0, cpu_rst}, (i == 31) ? 32'd0 : 32'd1);
      check("load_done",     {31'd0, boot_done}, (i == 31) ? 32'd1 : 32'd0);
    end

    // Bytes after DONE are ignored
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(8'h30 + i));
      check("done_we",      {31'd0, bus.mem_we}, 32'd0);
      check("done_cpu_rst", {31'd0, cpu_rst}, 32'd0);
      check("done_flag",    {31'd0, boot_done}, 32'd1);
    end
    check("done_addr", {27'd0, bus.mem_addr}, 32'd31);

    // Reset in DONE reasserts CPU reset and restarts at word 0
    bus.mem_ack = 1'b0;
    do_reset();
    check("redo_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("redo_done",    {31'd0, boot_done}, 32'd0);
    check("redo_addr",    {27'd0, bus.mem_addr}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

Interface
REQ-001 Parameter WORD_COUNT, default 32, SHALL set the number of 32-bit program words loaded before boot.
REQ-002 Parameter ADDR_WIDTH, default 5, SHALL set the word-address width; WORD_COUNT <= 2**ADDR_WIDTH.
REQ-003 sys_clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 sys_rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 rx_data  input  8  SHALL carry a received UART byte, valid only when rx_valid=1.
REQ-006 rx_valid  input  1  SHALL be a one-cycle pulse per received byte from the UART receiver.
REQ-007 mem_we  output  1  SHALL request a word write to program memory.
REQ-008 mem_addr  output  ADDR_WIDTH  SHALL give the word address of the pending write.
REQ-009 mem_wdata  output  32  SHALL give the word data of the pending write.
REQ-010 mem_ack  input  1  SHALL acknowledge the pending write; ignored while mem_we=0.
REQ-011 cpu_rst  output  1  SHALL hold the CPU in reset while 1.
REQ-012 boot_done  output  1  SHALL indicate all WORD_COUNT words are written.
REQ-013 overrun  output  1  SHALL flag (sticky) a dropped byte.

Function
REQ-014 States SHALL be RECV, WRITE, DONE; reset state RECV.
REQ-015 In RECV, each accepted byte SHALL be placed little-endian: byte k (k=0..3) into wdata bits [8k+7:8k]; a 2-bit byte index increments per byte.
REQ-016 When byte 3 is accepted at cycle N, the block SHALL present mem_we=1 with assembled word and current word index at cycle N+1 and enter WRITE.
REQ-017 In WRITE, mem_we, mem_addr, mem_wdata SHALL remain stable until mem_ack=1 is sampled.
REQ-018 mem_ack sampled at cycle M SHALL give mem_we=0 at M+1, word index +1, byte index 0.
REQ-019 After the ack of word index WORD_COUNT-1, the block SHALL enter DONE; otherwise return to RECV.
REQ-020 A byte arriving in WRITE SHALL be captured in a one-byte holding register and consumed as byte 0 of the next word in the first RECV cycle.
REQ-021 A byte arriving in WRITE while the holding register is full SHALL be discarded and set overrun=1 until reset.
REQ-022 rx_valid and mem_ack in the same cycle SHALL be handled as REQ-020 (byte held, ack completes).
REQ-023 A byte arriving in the same cycle the holding byte is consumed SHALL be accepted as the next byte; no overrun.
REQ-024 In DONE, cpu_rst SHALL be 0 and boot_done 1 from the first DONE cycle (one cycle after the final ack); rx_valid and mem_ack ignored; mem_we stays 0.
REQ-025 mem_addr SHALL never exceed WORD_COUNT-1; no wrap-around writes.

Reset
REQ-026 On sys_rst=1 at a clock edge: mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, boot_done=0, overrun=0, state RECV, byte/word indices 0, holding register empty.
REQ-027 sys_rst mid-word or mid-WRITE SHALL discard the partial word and pending write; no write SHALL complete after reset.
REQ-028 sys_rst in DONE SHALL reassert cpu_rst and restart loading at word 0.

Verification
REQ-029 Reset; bytes 78,56,34,12 -> one mem_we cycle-after-last-byte, mem_addr=0, mem_wdata=0x12345678.
REQ-030 32 words, mem_ack tied 1 -> 32 writes, addr 0..31 in order; cpu_rst=0 and boot_done=1 one cycle after 32nd ack.
REQ-031 mem_ack delayed 5 cycles, one byte 0xAA during WRITE -> outputs stable during wait; next word byte 0 = 0xAA; overrun=0.
REQ-032 Two bytes during one WRITE -> overrun=1 and stays 1; second byte absent from next word.
REQ-033 sys_rst after 2 bytes, then bytes 01,02,03,04 -> write addr=0, wdata=0x04030201.
REQ-034 After DONE, 8 more rx_valid bytes -> no mem_we, cpu_rst stays 0, boot_done stays 1.
